dt_thresh_pack: RTL and testbench

//  Downstream stage of the distance-transform (DT) engine. After DT asserts done, this block raster-scans
//  the 128x128x8b result RAM (res_*) and thresholds each distance value. It packs the binary mask into
//  16-bit words in the same layout as the sti ROM (1024 words) and reports max distance, its first

---
 rtl/dt_thresh_pack.sv | 197 +++++++++++++++++++
 tb/tb_dt_thresh_pack.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dt_thresh_pack.sv
// Threshold, pack and statistics stage behind the distance-transform result RAM.
// Optional per-value histogram enabled by defining HIST_EN.
//
// state | meaning
// IDLE  | waiting for start; results from the last scan held
// SCAN  | issuing result RAM reads 0..16383, one per cycle
// DRAIN | no new reads; consuming the final data beat
// FLUSH | final mask word written
// FIN   | done pulse
module dt_thresh_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  thr,
    output logic        busy,
    output logic        done,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic        msk_wr,
    output logic [9:0]  msk_addr,
    output logic [15:0] msk_do,
    output logic [7:0]  max_val,
    output logic [13:0] max_addr,
    output logic [14:0] fg_cnt,
    input  logic [3:0]  hist_sel,
    output logic [14:0] hist_cnt
);

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int WORD_W = 16;
    localparam logic [13:0] LAST_ADDR = 14'(IMG_W * IMG_H - 1);
    localparam logic [3:0]  LAST_COL  = 4'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_FLUSH,
        S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  thr_q, thr_d;
    logic [13:0] addr_q, addr_d;
    logic        vld_q, vld_d;
    logic [13:0] caddr_q, caddr_d;
    logic [14:0] pack_q, pack_d;
    logic        wr_q, wr_d;
    logic [9:0]  waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  max_val_q, max_val_d;
    logic [13:0] max_addr_q, max_addr_d;
    logic [14:0] fg_q, fg_d;
    logic        start_acc;
    logic        pix_bit;

    always_comb begin
        state_d    = state_q;
        thr_d      = thr_q;
        addr_d     = addr_q;
        vld_d      = (state_q == S_SCAN);
        caddr_d    = addr_q;
        pack_d     = pack_q;
        wr_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        max_val_d  = max_val_q;
        max_addr_d = max_addr_q;
        fg_d       = fg_q;
        start_acc  = 1'b0;
        pix_bit    = (res_di > thr_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_d    = S_SCAN;
                    thr_d      = thr;
                    addr_d     = '0;
                    pack_d     = '0;
                    max_val_d  = '0;
                    max_addr_d = '0;
                    fg_d       = '0;
                end
            end
            S_SCAN: begin
                addr_d = addr_q + 14'd1;
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_FLUSH;
            S_FLUSH: state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Data arrives one cycle after its address, so consumption lags the read pointer.
        if (vld_q) begin
            pack_d = {pack_q[13:0], pix_bit};
            if (res_di != 8'd0) begin
                fg_d = fg_q + 15'd1;
            end
            if (res_di > max_val_q) begin
                max_val_d  = res_di;
                max_addr_d = caddr_q;
            end
            if (caddr_q[3:0] == LAST_COL) begin
                wr_d    = 1'b1;
                waddr_d = caddr_q[13:4];
                wdata_d = {pack_q, pix_bit};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            thr_q      <= '0;
            addr_q     <= '0;
            vld_q      <= 1'b0;
            caddr_q    <= '0;
            pack_q     <= '0;
            wr_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            max_val_q  <= '0;
            max_addr_q <= '0;
            fg_q       <= '0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            addr_q     <= addr_d;
            vld_q      <= vld_d;
            caddr_q    <= caddr_d;
            pack_q     <= pack_d;
            wr_q       <= wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            max_val_q  <= max_val_d;
            max_addr_q <= max_addr_d;
            fg_q       <= fg_d;
        end
    end

    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done     = (state_q == S_FIN);
    assign res_rd   = (state_q == S_SCAN);
    assign res_addr = addr_q;
    assign msk_wr   = wr_q;
    assign msk_addr = waddr_q;
    assign msk_do   = wdata_q;
    assign max_val  = max_val_q;
    assign max_addr = max_addr_q;
    assign fg_cnt   = fg_q;

`ifdef HIST_EN
    localparam logic [14:0] HIST_MAX = 15'(IMG_W * IMG_H);

    logic [14:0] hist_q [16];
    logic [14:0] hist_d [16];
    logic [3:0]  hist_bin;

    always_comb begin
        hist_bin = (res_di >= 8'd15) ? 4'd15 : res_di[3:0];
        for (int i = 0; i < 16; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (start_acc) begin
            for (int i = 0; i < 16; i++) begin
                hist_d[i] = '0;
            end
        end else if (vld_q && (hist_q[hist_bin] != HIST_MAX)) begin
            hist_d[hist_bin] = hist_q[hist_bin] + 15'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (reset) begin
                hist_q[i] <= '0;
            end else begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    assign hist_cnt = hist_q[hist_sel];
`else
    logic unused_hist;
    assign unused_hist = ^{hist_sel, start_acc};
    assign hist_cnt    = '0;
`endif

endmodule

// File: tb/tb_dt_thresh_pack.sv
// Randomized self-checking bench for dt_thresh_pack against an image-level reference model.
module tb_dt_thresh_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  thr;
    logic        busy;
    logic        done;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        msk_wr;
    logic [9:0]  msk_addr;
    logic [15:0] msk_do;
    logic [7:0]  max_val;
    logic [13:0] max_addr;
    logic [14:0] fg_cnt;
    logic [3:0]  hist_sel;
    logic [14:0] hist_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mem [16384];
    logic [15:0] exp_words [1024];
    logic [7:0]  exp_max;
    logic [13:0] exp_maddr;
    int          exp_fg;
    int          exp_hist [16];

    dt_thresh_pack dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .thr      (thr),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .msk_wr   (msk_wr),
        .msk_addr (msk_addr),
        .msk_do   (msk_do),
        .max_val  (max_val),
        .max_addr (max_addr),
        .fg_cnt   (fg_cnt),
        .hist_sel (hist_sel),
        .hist_cnt (hist_cnt)
    );

    always #5 clk = ~clk;

    // Result RAM with a one-cycle synchronous read.
    always @(posedge clk) begin
        if (res_rd) res_di <= mem[res_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic build_model(input logic [7:0] t);
        int mx;
        for (int w = 0; w < 1024; w++) exp_words[w] = '0;
        for (int k = 0; k < 16; k++) exp_hist[k] = 0;
        exp_fg = 0;
        mx = 0;
        for (int a = 0; a < 16384; a++) begin
            if (mem[a] > t) exp_words[a / 16][15 - (a % 16)] = 1'b1;
            if (mem[a] != 0) exp_fg++;
            if (int'(mem[a]) > mx) mx = int'(mem[a]);
            exp_hist[(mem[a] >= 15) ? 15 : int'(mem[a])]++;
        end
        exp_max = 8'(mx);
        exp_maddr = '0;
        for (int a = 16383; a >= 0; a--) begin
            if (int'(mem[a]) == mx) exp_maddr = 14'(a);
        end
        for (int k = 0; k < 16; k++) if (exp_hist[k] > 16384) exp_hist[k] = 16384;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_res_rd"}, 32'(res_rd), 0);
        chk({tag, "_res_addr"}, 32'(res_addr), 0);
        chk({tag, "_msk_wr"}, 32'(msk_wr), 0);
        chk({tag, "_msk_addr"}, 32'(msk_addr), 0);
        chk({tag, "_msk_do"}, 32'(msk_do), 0);
        chk({tag, "_max_val"}, 32'(max_val), 0);
        chk({tag, "_max_addr"}, 32'(max_addr), 0);
        chk({tag, "_fg_cnt"}, 32'(fg_cnt), 0);
        chk({tag, "_hist"}, 32'(hist_cnt), 0);
    endtask

    // One scan; xs0/xs1 are extra start pulse cycles, rst_cyc>0 aborts with reset+start at that cycle.
    task automatic run_scan(input string name, input logic [7:0] t, input int xs0, input int xs1,
                            input int rst_cyc);
        int cyc, nwr, done_cyc, busy_bad, word_bad, order_bad, time_bad, stray;
        cyc = 0; nwr = 0; done_cyc = -1;
        busy_bad = 0; word_bad = 0; order_bad = 0; time_bad = 0;
        build_model(t);
        @(negedge clk);
        start = 1'b1;
        thr   = t;
        @(posedge clk);
        while (cyc < 17000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == xs0) || (cyc == xs1);
            thr   = 8'($urandom);
            if (busy !== ((cyc <= 16386) ? 1'b1 : 1'b0)) busy_bad++;
            if (cyc == 1) begin
                chk({name, "_rd_first"}, 32'(res_rd), 1);
                chk({name, "_addr_first"}, 32'(res_addr), 0);
            end
            if (cyc == 16384) begin
                chk({name, "_rd_last"}, 32'(res_rd), 1);
                chk({name, "_addr_last"}, 32'(res_addr), 16383);
            end
            if (cyc == 16385) chk({name, "_rd_drain"}, 32'(res_rd), 0);
            if (msk_wr === 1'b1) begin
                if (msk_addr !== 10'(nwr)) order_bad++;
                if (msk_do !== exp_words[msk_addr]) word_bad++;
                if (cyc != 18 + 16 * nwr) time_bad++;
                nwr++;
            end
            if (done === 1'b1) done_cyc = cyc;
            if (rst_cyc > 0 && cyc == rst_cyc) begin
                reset = 1'b1;
                start = 1'b1;
                @(negedge clk);
                chk_reset_vals({name, "_abort"});
                reset = 1'b0;
                start = 1'b0;
                stray = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (msk_wr !== 1'b0 || busy !== 1'b0 || res_rd !== 1'b0) stray++;
                end
                chk({name, "_abort_quiet"}, 32'(stray), 0);
                return;
            end
        end
        start = 1'b0;
        chk({name, "_done_cycle"}, 32'(done_cyc), 16387);
        chk({name, "_busy_profile"}, 32'(busy_bad), 0);
        chk({name, "_wr_count"}, 32'(nwr), 1024);
        chk({name, "_wr_order"}, 32'(order_bad), 0);
        chk({name, "_wr_timing"}, 32'(time_bad), 0);
        chk({name, "_words"}, 32'(word_bad), 0);
        chk({name, "_max_val"}, 32'(max_val), 32'(exp_max));
        chk({name, "_max_addr"}, 32'(max_addr), 32'(exp_maddr));
        chk({name, "_fg_cnt"}, 32'(fg_cnt), 32'(exp_fg));
`ifdef HIST_EN
        for (int k = 0; k < 16; k++) begin
            hist_sel = 4'(k);
            #1;
            chk($sformatf("%s_hist%0d", name, k), 32'(hist_cnt), 32'(exp_hist[k]));
        end
`else
        hist_sel = 4'($urandom);
        #1;
        chk({name, "_hist_tied"}, 32'(hist_cnt), 0);
`endif
        repeat (5) @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 0);
        chk({name, "_hold_max"}, 32'(max_val), 32'(exp_max));
        chk({name, "_hold_fg"}, 32'(fg_cnt), 32'(exp_fg));
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        thr      = '0;
        hist_sel = '0;
        for (int a = 0; a < 16384; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        run_scan("zero", 8'd0, -1, -1, 0);

        mem[14'h0191] = 8'd5;
        mem[200] = 8'd9;
        mem[100] = 8'd9;
        run_scan("sparse", 8'd4, -1, -1, 0);
        chk("sparse_max_addr_100", 32'(max_addr), 100);
        chk("sparse_word25", 32'(exp_words[25]), 32'h4000);
        chk("sparse_fg3", 32'(fg_cnt), 3);

        for (int a = 0; a < 16384; a++) mem[a] = 8'hFF;
        run_scan("full", 8'd254, 50, 16000, 0);
        chk("full_fg", 32'(fg_cnt), 16384);

        for (int a = 0; a < 16384; a++)
            mem[a] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        run_scan("abort", 8'($urandom), -1, -1, 3000);

        for (int a = 0; a < 16384; a++)
            mem[a] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255));
        run_scan("random", 8'($urandom_range(0, 255)), -1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
